hazard_fwd_ctrl: RTL
====================

// Module: hazard_fwd_ctrl
// PURPOSE
//  Parametrised hazard and forwarding controller for the 5-stage pipeline; sits beside ID and EX.
//  Generates EX-stage ALU operand forwarding selects and ID-stage branch-compare forwarding selects.
//  Generates load-use and branch-in-ID stall/bubble controls, plus a multi-cycle (MUL) EX hold state machine.
//  Also maintains a saturating stall-cycle performance counter.
// PARAMETERS
//  REG_AW   5   register-address width; register 0 is hardwired zero and is never forwarded.
//  MUL_LAT  3   EX occupancy of a multi-cycle op, in cycles; legal range 2..16.
//  CNT_W    32  width of the stall_cycles counter.
// PORTS
//  clk           in   1       pipeline clock
//  rst           in   1       asynchronous, active-high reset
//  id_rs,id_rt   in   REG_AW  source registers of the instruction in IF/ID
//  id_use_rs/rt  in   1       the ID instruction actually reads rs/rt
//  id_branch     in   1       beq/bne in ID; compare is resolved in ID
//  ex_rs,ex_rt   in   REG_AW  ID/EX source registers
//  ex_wreg       in   REG_AW  ID/EX destination register, already decoded (rd or rt)
//  ex_regwrite   in   1       ID/EX.RegWrite
//  ex_memread    in   1       ID/EX.MemRead
//  ex_mul        in   1       level: a multi-cycle op occupies EX
//  mem_wreg      in   REG_AW  EX/MEM destination register
//  mem_regwrite  in   1       EX/MEM.RegWrite
//  mem_memread   in   1       EX/MEM.MemRead
//  wb_wreg       in   REG_AW  MEM/WB destination register
//  wb_regwrite   in   1       MEM/WB.RegWrite
//  fwd_a,fwd_b   out  2       ALU A/B select: 00 ID/EX, 10 EX/MEM, 01 MEM/WB
//  br_fwd_a/b    out  1       ID compare operand from EX/MEM ALU result
//  stall_if      out  1       hold PC
//  stall_id      out  1       hold IF/ID
//  flush_ex      out  1       load a bubble into ID/EX
//  ex_hold       out  1       hold ID/EX; load a bubble into EX/MEM
//  mul_done      out  1       one-cycle pulse on the last cycle of a MUL op in EX
//  stall_cycles  out  CNT_W   count of cycles with stall_id=1
// BEHAVIOUR
//  Reset (async):
//   - FSM goes to IDLE, cnt=0, stall_cycles=0.
//   - All combinational outputs are forced to 0 while rst=1.
//  match(s,w,we) = we & (w!=0) & (w==s).
//  EX forwarding (A uses ex_rs, B uses ex_rt), evaluated independently for each operand:
//   - 10 if match(.,mem_wreg,mem_regwrite).
//   - Otherwise 01 if match(.,wb_wreg,wb_regwrite).
//   - Otherwise 00.
//  ID branch forwarding:
//   - br_fwd_a = id_branch & id_use_rs & match(id_rs,mem_wreg,mem_regwrite) & !mem_memread; br_fwd_b likewise with rt.
//   - MEM/WB needs no ID forwarding: the register file is write-before-read.
//  Hazard terms:
//   - load_use = ex_memread & (id_use_rs&match(id_rs,ex_wreg,ex_regwrite) | id_use_rt&match(id_rt,...)).
//   - br_ex = id_branch & the same rs/rt match against ex_wreg/ex_regwrite (any EX producer).
//   - br_ld2 = id_branch & mem_memread & rs/rt match against mem_wreg/mem_regwrite.
//   - br_ex then br_ld2 gives a load feeding a branch exactly 2 stall cycles.
//  MUL FSM:
//   - IDLE: if ex_mul, ex_hold=1, cnt<=MUL_LAT-2, next state BUSY.
//   - BUSY: ex_hold=(cnt!=0); cnt decrements when nonzero.
//   - BUSY with cnt==0: mul_done=1, ex_hold=0 (op advances), next state IDLE.
//   - Net effect: ex_hold is high for exactly MUL_LAT-1 consecutive cycles per MUL op.
//   - Back-to-back MUL: IDLE sees ex_mul again on the next cycle and restarts.
//  Output combine:
//   - stall_if = stall_id = ex_hold | load_use | br_ex | br_ld2.
//   - flush_ex = !ex_hold & (load_use | br_ex | br_ld2); a hold takes priority and ID/EX keeps the MUL op.
//   - Forwarding selects stay valid during a hold.
//  stall_cycles increments on each clk with stall_id=1 and saturates at all-ones (no wrap).
//  rst asserted mid-MUL: FSM aborts to IDLE; ex_hold and mul_done drop immediately.
// TESTING
//  1. EX/MEM and MEM/WB both write r5, ex_rs=5 -> fwd_a=10; mem_wreg=0 with mem_regwrite=1 -> fwd_a=01.
//  2. lw r3 in EX, add using r3 in ID -> one cycle stall_if=stall_id=flush_ex=1; next cycle all 0, fwd_a=01.
//  3. lw r4 then beq r4 -> 2 stall cycles (br_ex, then br_ld2); then br_fwd_a=0, stall_cycles=2.
//  4. add r6 then beq r6 -> 1 stall; next cycle br_fwd_a=1, no stall.
//  5. MUL_LAT=3, ex_mul for 3 cycles -> ex_hold 1,1,0, mul_done on cycle 3, flush_ex=0 throughout even with load_use.
//  6. rst pulsed in BUSY -> all outputs 0 asynchronously, counter 0; force counter to max-1, stall 3 cycles -> holds all-ones.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Also sequences multi-cycle MUL occupancy of EX and counts stall cycles.
module hazard_fwd_ctrl #(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] i_id_rs,
   input  logic [REG_AW-1:0] i_id_rt,
   input  logic              i_id_use_rs,
   input  logic              i_id_use_rt,
   input  logic              i_id_branch,
   input  logic [REG_AW-1:0] i_ex_rs,
   input  logic [REG_AW-1:0] i_ex_rt,
   input  logic [REG_AW-1:0] i_ex_wreg,
   input  logic              i_ex_regwrite,
   input  logic              i_ex_memread,
   input  logic              i_ex_mul,
   input  logic [REG_AW-1:0] i_mem_wreg,
   input  logic              i_mem_regwrite,
   input  logic              i_mem_memread,
   input  logic [REG_AW-1:0] i_wb_wreg,
   input  logic              i_wb_regwrite,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b,
   output logic              o_br_fwd_a,
   output logic              o_br_fwd_b,
   output logic              o_stall_if,
   output logic              o_stall_id,
   output logic              o_flush_ex,
   output logic              o_ex_hold,
   output logic              o_mul_done,
   output logic [CNT_W-1:0]  o_stall_cycles
);

   localparam int unsigned CW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 2);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic             w_ex_hold;
   logic             w_mul_done;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;
   logic             w_br_fwd_a;
   logic             w_br_fwd_b;
   logic             w_ex_dep;
   logic             w_mem_dep;
   logic             w_load_use;
   logic             w_br_ex;
   logic             w_br_ld2;
   logic             w_stall;
   logic             w_flush;
   logic [CNT_W-1:0] r_stall_cycles;

   function automatic logic f_match(input logic [REG_AW-1:0] s, input logic [REG_AW-1:0] w,
                                    input logic we);
      return we && (w != '0) && (w == s);
   endfunction

   // EX/MEM has priority over MEM/WB since it holds the younger result
   always_comb begin
      w_fwd_a = 2'b00;
      w_fwd_b = 2'b00;
      if (f_match(i_ex_rs, i_mem_wreg, i_mem_regwrite))     w_fwd_a = 2'b10;
      else if (f_match(i_ex_rs, i_wb_wreg, i_wb_regwrite))  w_fwd_a = 2'b01;
      if (f_match(i_ex_rt, i_mem_wreg, i_mem_regwrite))     w_fwd_b = 2'b10;
      else if (f_match(i_ex_rt, i_wb_wreg, i_wb_regwrite))  w_fwd_b = 2'b01;
   end

   always_comb begin
      w_br_fwd_a = i_id_branch & i_id_use_rs & f_match(i_id_rs, i_mem_wreg, i_mem_regwrite)
                   & ~i_mem_memread;
      w_br_fwd_b = i_id_branch & i_id_use_rt & f_match(i_id_rt, i_mem_wreg, i_mem_regwrite)
                   & ~i_mem_memread;
      w_ex_dep   = (i_id_use_rs & f_match(i_id_rs, i_ex_wreg, i_ex_regwrite))
                 | (i_id_use_rt & f_match(i_id_rt, i_ex_wreg, i_ex_regwrite));
      w_mem_dep  = (i_id_use_rs & f_match(i_id_rs, i_mem_wreg, i_mem_regwrite))
                 | (i_id_use_rt & f_match(i_id_rt, i_mem_wreg, i_mem_regwrite));
      w_load_use = i_ex_memread & w_ex_dep;
      w_br_ex    = i_id_branch & w_ex_dep;
      w_br_ld2   = i_id_branch & i_mem_memread & w_mem_dep;
      w_stall    = w_ex_hold | w_load_use | w_br_ex | w_br_ld2;
      // A MUL hold keeps the op in ID/EX, so no bubble may overwrite it
      w_flush    = ~w_ex_hold & (w_load_use | w_br_ex | w_br_ld2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (i_ex_mul) begin
               w_state_nxt = S_BUSY;
               w_cnt_nxt   = CNT_INIT;
            end
         end
         S_BUSY: begin
            if (r_cnt != '0) w_cnt_nxt   = r_cnt - CW'(1);
            else             w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_ex_hold  = 1'b0;
      w_mul_done = 1'b0;
      case (r_state)
         S_IDLE: w_ex_hold = i_ex_mul;
         S_BUSY: begin
            w_ex_hold  = (r_cnt != '0);
            w_mul_done = (r_cnt == '0);
         end
         default: ;
      endcase
   end

   // Saturating stall counter; never wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_stall_cycles <= '0;
      else if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
   end

   assign o_fwd_a        = rst ? 2'b00 : w_fwd_a;
   assign o_fwd_b        = rst ? 2'b00 : w_fwd_b;
   assign o_br_fwd_a     = ~rst & w_br_fwd_a;
   assign o_br_fwd_b     = ~rst & w_br_fwd_b;
   assign o_stall_if     = ~rst & w_stall;
   assign o_stall_id     = ~rst & w_stall;
   assign o_flush_ex     = ~rst & w_flush;
   assign o_ex_hold      = ~rst & w_ex_hold;
   assign o_mul_done     = ~rst & w_mul_done;
   assign o_stall_cycles = r_stall_cycles;

endmodule
